// File: rtl/ahb_bus_matrix_in_stage.sv
// Slave-side input stage of the AHB bus matrix. An address phase that the
// output stage cannot take at once is captured, the master is stalled, and
// the captured phase is replayed when the output stage grants this port.
// The data-phase ready/response from the owning output stage is returned
// to the master.
//
// Handshake: a transfer is presented on *_ip whenever held_tran_ip=1; it is
// taken by an output stage in a cycle where active_ip=1 and readyout_ip=1
// (accept). A presented transfer is kept stable until it is accepted.
module ahb_bus_matrix_in_stage #(
  parameter int ADDR_W  = 32,
  parameter int AUSER_W = 32,
  parameter int MID_W   = 4
) (
  input  logic               HCLK,
  input  logic               HRESETn,
  input  logic               HSELS,
  input  logic [ADDR_W-1:0]  HADDRS,
  input  logic [AUSER_W-1:0] HAUSERS,
  input  logic [1:0]         HTRANSS,
  input  logic               HWRITES,
  input  logic [2:0]         HSIZES,
  input  logic [2:0]         HBURSTS,
  input  logic [3:0]         HPROTS,
  input  logic [MID_W-1:0]   HMASTERS,
  input  logic               HMASTLOCKS,
  input  logic               HREADYS,
  input  logic               active_ip,
  input  logic               readyout_ip,
  input  logic               resp_ip,
  output logic               sel_ip,
  output logic [ADDR_W-1:0]  addr_ip,
  output logic [AUSER_W-1:0] auser_ip,
  output logic [1:0]         trans_ip,
  output logic               write_ip,
  output logic [2:0]         size_ip,
  output logic [2:0]         burst_ip,
  output logic [3:0]         prot_ip,
  output logic [MID_W-1:0]   master_ip,
  output logic               mastlock_ip,
  output logic               held_tran_ip,
  output logic               HREADYOUTS,
  output logic               HRESPS
);

  localparam logic [1:0] TRANS_NONSEQ = 2'b10;
  localparam logic [1:0] TRANS_SEQ    = 2'b11;
  localparam logic [2:0] BURST_SINGLE = 3'b000;
  localparam logic [2:0] BURST_INCR   = 3'b001;

  logic               pend_tran;
  logic               data_phase;
  logic               trans_valid;
  logic               accept;
  logic               capture;

  logic               hold_sel;
  logic [ADDR_W-1:0]  hold_addr;
  logic [AUSER_W-1:0] hold_auser;
  logic [1:0]         hold_trans;
  logic               hold_write;
  logic [2:0]         hold_size;
  logic [2:0]         hold_burst;
  logic [3:0]         hold_prot;
  logic [MID_W-1:0]   hold_master;
  logic               hold_mastlock;

  // IDLE and BUSY never start a transfer; HTRANSS[1] marks NONSEQ/SEQ.
  assign trans_valid  = HSELS & HREADYS & HTRANSS[1];
  assign held_tran_ip = pend_tran | trans_valid;
  assign accept       = held_tran_ip & active_ip & readyout_ip;
  // Bus activity is ignored while a transfer is already held (frozen hold).
  assign capture      = trans_valid & ~accept & ~pend_tran;

  // Pending flag: set when a live transfer is not taken, cleared on replay.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      pend_tran <= 1'b0;
    end else if (pend_tran && accept) begin
      pend_tran <= 1'b0;
    end else if (capture) begin
      pend_tran <= 1'b1;
    end
  end

  // Data-phase flag: opens on accept, closes when the owner reports ready.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      data_phase <= 1'b0;
    end else if (accept) begin
      data_phase <= 1'b1;
    end else if (readyout_ip) begin
      data_phase <= 1'b0;
    end
  end

  // Hold registers: load the full address phase only on capture.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      hold_sel      <= 1'b0;
      hold_addr     <= '0;
      hold_auser    <= '0;
      hold_trans    <= 2'b00;
      hold_write    <= 1'b0;
      hold_size     <= 3'b000;
      hold_burst    <= 3'b000;
      hold_prot     <= 4'b0000;
      hold_master   <= '0;
      hold_mastlock <= 1'b0;
    end else if (capture) begin
      hold_sel      <= HSELS;
      hold_addr     <= HADDRS;
      hold_auser    <= HAUSERS;
      hold_trans    <= HTRANSS;
      hold_write    <= HWRITES;
      hold_size     <= HSIZES;
      hold_burst    <= HBURSTS;
      hold_prot     <= HPROTS;
      hold_master   <= HMASTERS;
      hold_mastlock <= HMASTLOCKS;
    end
  end

  // Address mux: held phase while pending, otherwise live pass-through.
  // A replayed SEQ becomes NONSEQ (and a non-SINGLE burst becomes INCR)
  // because the slave never saw the beat that preceded it.
  always_comb begin
    sel_ip      = HSELS;
    addr_ip     = HADDRS;
    auser_ip    = HAUSERS;
    trans_ip    = HTRANSS;
    write_ip    = HWRITES;
    size_ip     = HSIZES;
    burst_ip    = HBURSTS;
    prot_ip     = HPROTS;
    master_ip   = HMASTERS;
    mastlock_ip = HMASTLOCKS;
    if (pend_tran) begin
      sel_ip      = hold_sel;
      addr_ip     = hold_addr;
      auser_ip    = hold_auser;
      trans_ip    = hold_trans;
      write_ip    = hold_write;
      size_ip     = hold_size;
      burst_ip    = hold_burst;
      prot_ip     = hold_prot;
      master_ip   = hold_master;
      mastlock_ip = hold_mastlock;
      if (hold_trans == TRANS_SEQ) begin
        trans_ip = TRANS_NONSEQ;
        if (hold_burst != BURST_SINGLE) begin
          burst_ip = BURST_INCR;
        end
      end
    end
  end

  // Master-facing ready/response: stall while pending, else follow owner.
  always_comb begin
    HREADYOUTS = 1'b1;
    HRESPS     = 1'b0;
    if (pend_tran) begin
      HREADYOUTS = 1'b0;
    end else if (data_phase) begin
      HREADYOUTS = readyout_ip;
    end
    if (data_phase) begin
      HRESPS = resp_ip;
    end
  end

endmodule

// File: tb/tb_ahb_bus_matrix_in_stage.sv
// Directed bench for ahb_bus_matrix_in_stage: pass-through grant, held
// transfer with replay, burst split rewrite, error response, reset during
// a hold, and non-transfer inputs.
module tb_ahb_bus_matrix_in_stage;

  localparam int ADDR_W  = 32;
  localparam int AUSER_W = 32;
  localparam int MID_W   = 4;

  logic               HCLK;
  logic               HRESETn;
  logic               HSELS;
  logic [ADDR_W-1:0]  HADDRS;
  logic [AUSER_W-1:0] HAUSERS;
  logic [1:0]         HTRANSS;
  logic               HWRITES;
  logic [2:0]         HSIZES;
  logic [2:0]         HBURSTS;
  logic [3:0]         HPROTS;
  logic [MID_W-1:0]   HMASTERS;
  logic               HMASTLOCKS;
  logic               HREADYS;
  logic               active_ip;
  logic               readyout_ip;
  logic               resp_ip;
  logic               sel_ip;
  logic [ADDR_W-1:0]  addr_ip;
  logic [AUSER_W-1:0] auser_ip;
  logic [1:0]         trans_ip;
  logic               write_ip;
  logic [2:0]         size_ip;
  logic [2:0]         burst_ip;
  logic [3:0]         prot_ip;
  logic [MID_W-1:0]   master_ip;
  logic               mastlock_ip;
  logic               held_tran_ip;
  logic               HREADYOUTS;
  logic               HRESPS;

  int checks;
  int errors;
  logic [ADDR_W-1:0] exp_q[$];

  ahb_bus_matrix_in_stage #(
    .ADDR_W(ADDR_W), .AUSER_W(AUSER_W), .MID_W(MID_W)
  ) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .HSELS(HSELS), .HADDRS(HADDRS),
    .HAUSERS(HAUSERS), .HTRANSS(HTRANSS), .HWRITES(HWRITES),
    .HSIZES(HSIZES), .HBURSTS(HBURSTS), .HPROTS(HPROTS),
    .HMASTERS(HMASTERS), .HMASTLOCKS(HMASTLOCKS), .HREADYS(HREADYS),
    .active_ip(active_ip), .readyout_ip(readyout_ip), .resp_ip(resp_ip),
    .sel_ip(sel_ip), .addr_ip(addr_ip), .auser_ip(auser_ip),
    .trans_ip(trans_ip), .write_ip(write_ip), .size_ip(size_ip),
    .burst_ip(burst_ip), .prot_ip(prot_ip), .master_ip(master_ip),
    .mastlock_ip(mastlock_ip), .held_tran_ip(held_tran_ip),
    .HREADYOUTS(HREADYOUTS), .HRESPS(HRESPS)
  );

  // Clock
  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp_v);
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp_v, $time);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic next_cycle();
    @(posedge HCLK);
    #1;
  endtask

  // Go to the sampling point of the current cycle.
  task automatic sample_point();
    @(negedge HCLK);
  endtask

  task automatic bus_idle();
    HSELS      = 1'b0;
    HTRANSS    = 2'b00;
    HADDRS     = '0;
    HWRITES    = 1'b0;
    HBURSTS    = 3'b000;
    HSIZES     = 3'b010;
    HPROTS     = 4'b0011;
    HAUSERS    = '0;
    HMASTERS   = 4'h1;
    HMASTLOCKS = 1'b0;
  endtask

  task automatic drive_addr(input logic [1:0] trans, input logic [ADDR_W-1:0] addr,
                            input logic wr, input logic [2:0] burst);
    HSELS   = 1'b1;
    HTRANSS = trans;
    HADDRS  = addr;
    HWRITES = wr;
    HBURSTS = burst;
  endtask

  // Scoreboard: every accepted transfer must match the next expected address.
  // Also the pend_tran / data_phase invariant.
  always @(negedge HCLK) begin
    if (HRESETn) begin
      check("inv_pend_dp", {63'd0, dut.pend_tran & dut.data_phase}, 64'd0);
      if (held_tran_ip && active_ip && readyout_ip) begin
        if (exp_q.size() == 0) begin
          check("sb_unexpected_accept", 64'd1, 64'd0);
        end else begin
          check("sb_addr", {32'd0, addr_ip}, {32'd0, exp_q.pop_front()});
        end
      end
    end
  end

  initial begin
    checks = 0;
    errors = 0;
    bus_idle();
    HREADYS     = 1'b1;
    active_ip   = 1'b0;
    readyout_ip = 1'b1;
    resp_ip     = 1'b0;
    HRESETn     = 1'b0;

    // Reset state
    repeat (2) @(posedge HCLK);
    sample_point();
    check("rst_hreadyout", {63'd0, HREADYOUTS}, 64'd1);
    check("rst_hresp", {63'd0, HRESPS}, 64'd0);
    check("rst_held", {63'd0, held_tran_ip}, 64'd0);
    next_cycle();
    HRESETn = 1'b1;
    next_cycle();

    // 1: idle grant, zero-latency pass-through
    drive_addr(2'b10, 32'h2000_0000, 1'b0, 3'b000);
    active_ip = 1'b1;
    exp_q.push_back(32'h2000_0000);
    sample_point();
    check("t1_trans", {62'd0, trans_ip}, 64'd2);
    check("t1_addr", {32'd0, addr_ip}, 64'h2000_0000);
    check("t1_held", {63'd0, held_tran_ip}, 64'd1);
    check("t1_hreadyout", {63'd0, HREADYOUTS}, 64'd1);
    next_cycle();
    bus_idle();
    active_ip = 1'b0;
    sample_point();
    check("t1_no_pend", {63'd0, dut.pend_tran}, 64'd0);
    check("t1_dp_ready", {63'd0, HREADYOUTS}, 64'd1);
    next_cycle();

    // 2: held write, three stall cycles, then replay
    drive_addr(2'b10, 32'h4000_0010, 1'b1, 3'b000);
    HMASTLOCKS = 1'b1;
    sample_point();
    check("t2_held_live", {63'd0, held_tran_ip}, 64'd1);
    next_cycle();
    // Bus changes during the wait must not disturb the held phase.
    HREADYS = 1'b0;
    drive_addr(2'b10, 32'hDEAD_0000, 1'b0, 3'b011);
    HMASTLOCKS = 1'b0;
    for (int i = 0; i < 3; i++) begin
      sample_point();
      check("t2_stall", {63'd0, HREADYOUTS}, 64'd0);
      check("t2_held", {63'd0, held_tran_ip}, 64'd1);
      check("t2_addr_frozen", {32'd0, addr_ip}, 64'h4000_0010);
      check("t2_write", {63'd0, write_ip}, 64'd1);
      check("t2_lock", {63'd0, mastlock_ip}, 64'd1);
      next_cycle();
    end
    active_ip = 1'b1;
    exp_q.push_back(32'h4000_0010);
    sample_point();
    check("t2_replay_addr", {32'd0, addr_ip}, 64'h4000_0010);
    check("t2_replay_stall", {63'd0, HREADYOUTS}, 64'd0);
    next_cycle();
    bus_idle();
    active_ip   = 1'b0;
    readyout_ip = 1'b0;
    sample_point();
    check("t2_dp_wait", {63'd0, HREADYOUTS}, 64'd0);
    next_cycle();
    readyout_ip = 1'b1;
    sample_point();
    check("t2_dp_done", {63'd0, HREADYOUTS}, 64'd1);
    next_cycle();
    HREADYS = 1'b1;

    // 3: INCR4 split, beat 2 (SEQ 0x104) held and replayed as NONSEQ/INCR
    drive_addr(2'b10, 32'h0000_0100, 1'b0, 3'b011);
    active_ip = 1'b1;
    exp_q.push_back(32'h0000_0100);
    next_cycle();
    drive_addr(2'b11, 32'h0000_0104, 1'b0, 3'b011);
    active_ip = 1'b0;
    sample_point();
    check("t3_beat1_ready", {63'd0, HREADYOUTS}, 64'd1);
    check("t3_live_seq", {62'd0, trans_ip}, 64'd3);
    next_cycle();
    HREADYS = 1'b0;
    sample_point();
    check("t3_stall", {63'd0, HREADYOUTS}, 64'd0);
    check("t3_trans_rw", {62'd0, trans_ip}, 64'd2);
    check("t3_burst_rw", {61'd0, burst_ip}, 64'd1);
    next_cycle();
    active_ip = 1'b1;
    exp_q.push_back(32'h0000_0104);
    sample_point();
    check("t3_replay_trans", {62'd0, trans_ip}, 64'd2);
    check("t3_replay_burst", {61'd0, burst_ip}, 64'd1);
    check("t3_replay_addr", {32'd0, addr_ip}, 64'h0000_0104);
    next_cycle();
    bus_idle();
    active_ip = 1'b0;
    HREADYS   = 1'b1;
    next_cycle();

    // 4: error response over a wait state
    drive_addr(2'b10, 32'h3000_0000, 1'b0, 3'b000);
    active_ip = 1'b1;
    exp_q.push_back(32'h3000_0000);
    next_cycle();
    bus_idle();
    active_ip   = 1'b0;
    HREADYS     = 1'b0;
    readyout_ip = 1'b0;
    resp_ip     = 1'b1;
    sample_point();
    check("t4_err1_resp", {63'd0, HRESPS}, 64'd1);
    check("t4_err1_ready", {63'd0, HREADYOUTS}, 64'd0);
    next_cycle();
    readyout_ip = 1'b1;
    sample_point();
    check("t4_err2_resp", {63'd0, HRESPS}, 64'd1);
    check("t4_err2_ready", {63'd0, HREADYOUTS}, 64'd1);
    next_cycle();
    resp_ip = 1'b0;
    HREADYS = 1'b1;
    sample_point();
    check("t4_after_resp", {63'd0, HRESPS}, 64'd0);
    next_cycle();

    // 5: reset while a transfer is held; nothing is replayed afterwards
    drive_addr(2'b10, 32'h5000_0000, 1'b1, 3'b000);
    next_cycle();
    bus_idle();
    sample_point();
    check("t5_pending", {63'd0, HREADYOUTS}, 64'd0);
    #2;
    HRESETn = 1'b0;
    #1;
    check("t5_rst_ready", {63'd0, HREADYOUTS}, 64'd1);
    check("t5_rst_held", {63'd0, held_tran_ip}, 64'd0);
    next_cycle();
    HRESETn   = 1'b1;
    active_ip = 1'b1;
    for (int i = 0; i < 3; i++) begin
      sample_point();
      check("t5_no_replay", {63'd0, held_tran_ip}, 64'd0);
      check("t5_ready", {63'd0, HREADYOUTS}, 64'd1);
      next_cycle();
    end
    active_ip = 1'b0;

    // 6: BUSY, and NONSEQ without select, are not transfers
    drive_addr(2'b01, 32'h6000_0000, 1'b0, 3'b001);
    sample_point();
    check("t6_busy_held", {63'd0, held_tran_ip}, 64'd0);
    next_cycle();
    sample_point();
    check("t6_busy_nocap", {63'd0, dut.pend_tran}, 64'd0);
    check("t6_busy_ready", {63'd0, HREADYOUTS}, 64'd1);
    drive_addr(2'b10, 32'h6000_0004, 1'b0, 3'b000);
    HSELS = 1'b0;
    next_cycle();
    sample_point();
    check("t6_nosel_held", {63'd0, held_tran_ip}, 64'd0);
    next_cycle();
    sample_point();
    check("t6_nosel_nocap", {63'd0, dut.pend_tran}, 64'd0);
    check("t6_nosel_ready", {63'd0, HREADYOUTS}, 64'd1);
    next_cycle();

    check("sb_empty", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
